// File: rtl/dut_bus_arb.sv
// Round-robin arbiter and burst sequencer sharing one registered cmd/adr/data bus
// between NUM_REQ requesters. Define DUT_ARB_LOCK_EN to add burst locking (req_lock).
module dut_bus_arb #(
    parameter int NUM_REQ = 4,
    parameter int W       = 4,
    parameter int LEN_W   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    input  logic [NUM_REQ*W-1:0]     req_cmd,
    input  logic [NUM_REQ*W-1:0]     req_adr,
    input  logic [NUM_REQ*W-1:0]     req_data,
`ifdef DUT_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]       req_lock,
`endif
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       beat_ack,
    output logic [W-1:0]             bus_cmd,
    output logic [W-1:0]             bus_adr,
    output logic [W-1:0]             bus_data,
    output logic                     bus_vld,
    output logic                     busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] GNT_ONE = NUM_REQ'(1);
    localparam logic [LEN_W-1:0]   CNT_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0]   CNT_ZERO = {LEN_W{1'b0}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       bus_cmd_q, bus_cmd_d;
    logic [W-1:0]       bus_adr_q, bus_adr_d;
    logic [W-1:0]       bus_data_q, bus_data_d;
    logic               bus_vld_q, bus_vld_d;

    logic               pick_vld_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic [LEN_W-1:0]   pick_len_s;
    logic [LEN_W-1:0]   win_len_s;
    logic [W-1:0]       win_cmd_s, win_adr_s, win_data_s;
    logic               relock_s;

    // Round-robin search starting one past the previous winner.
    always_comb begin
        int idx;
        idx        = 0;
        pick_vld_s = 1'b0;
        pick_idx_s = last_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_q) + k;
            idx = (idx >= NUM_REQ) ? idx - NUM_REQ : idx;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pick_vld_s && (idx == i) && req[i]) begin
                    pick_vld_s = 1'b1;
                    pick_idx_s = IDX_W'(i);
                end else begin
                    pick_vld_s = pick_vld_s;
                end
            end
        end
    end

    // Field muxes for the requester being picked and the one currently granted.
    always_comb begin
        pick_len_s = CNT_ZERO;
        win_len_s  = CNT_ZERO;
        win_cmd_s  = {W{1'b0}};
        win_adr_s  = {W{1'b0}};
        win_data_s = {W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            pick_len_s = (pick_idx_s == IDX_W'(i)) ? req_len[i*LEN_W +: LEN_W] : pick_len_s;
            win_len_s  = (last_q == IDX_W'(i)) ? req_len[i*LEN_W +: LEN_W] : win_len_s;
            win_cmd_s  = (last_q == IDX_W'(i)) ? req_cmd[i*W +: W]         : win_cmd_s;
            win_adr_s  = (last_q == IDX_W'(i)) ? req_adr[i*W +: W]         : win_adr_s;
            win_data_s = (last_q == IDX_W'(i)) ? req_data[i*W +: W]        : win_data_s;
        end
    end

`ifdef DUT_ARB_LOCK_EN
    logic [1:0] lock_cnt_q, lock_cnt_d;

    // A lock may extend a tenure to four bursts in total, then IDLE is forced.
    assign relock_s = (lock_cnt_q != 2'd3) && req_lock[last_q] && req[last_q];

    // Count relocks within the current grant tenure.
    always_comb begin
        if (state_q == IDLE) begin
            lock_cnt_d = 2'd0;
        end else if ((cnt_q == CNT_ZERO) && relock_s) begin
            lock_cnt_d = lock_cnt_q + 2'd1;
        end else begin
            lock_cnt_d = lock_cnt_q;
        end
    end

    // Lock counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_cnt_q <= 2'd0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
        end
    end
`else
    assign relock_s = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        case (state_q)
            IDLE:    state_d = pick_vld_s ? XFER : IDLE;
            XFER:    state_d = ((cnt_q == CNT_ZERO) && !relock_s) ? IDLE : XFER;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; grant and ack are masked in the reset cycle so the abort is immediate.
    always_comb begin
        if ((state_q == XFER) && !rst) begin
            gnt      = gnt_q;
            beat_ack = gnt_q;
        end else begin
            gnt      = {NUM_REQ{1'b0}};
            beat_ack = {NUM_REQ{1'b0}};
        end
        busy = (state_q == XFER);
    end

    // Grant, pointer, beat counter and bus next values.
    always_comb begin
        gnt_d      = gnt_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        bus_cmd_d  = {W{1'b0}};
        bus_adr_d  = {W{1'b0}};
        bus_data_d = {W{1'b0}};
        bus_vld_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld_s) begin
                    gnt_d  = GNT_ONE << pick_idx_s;
                    last_d = pick_idx_s;
                    cnt_d  = pick_len_s;
                end else begin
                    gnt_d  = {NUM_REQ{1'b0}};
                end
            end
            XFER: begin
                bus_cmd_d  = win_cmd_s;
                bus_adr_d  = win_adr_s;
                bus_data_d = win_data_s;
                bus_vld_d  = 1'b1;
                if (cnt_q == CNT_ZERO) begin
                    if (relock_s) begin
                        cnt_d = win_len_s;
                    end else begin
                        gnt_d = {NUM_REQ{1'b0}};
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                gnt_d = {NUM_REQ{1'b0}};
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q      <= {NUM_REQ{1'b0}};
            last_q     <= IDX_W'(NUM_REQ - 1);
            cnt_q      <= CNT_ZERO;
            bus_cmd_q  <= {W{1'b0}};
            bus_adr_q  <= {W{1'b0}};
            bus_data_q <= {W{1'b0}};
            bus_vld_q  <= 1'b0;
        end else begin
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            bus_cmd_q  <= bus_cmd_d;
            bus_adr_q  <= bus_adr_d;
            bus_data_q <= bus_data_d;
            bus_vld_q  <= bus_vld_d;
        end
    end

    assign bus_cmd  = bus_cmd_q;
    assign bus_adr  = bus_adr_q;
    assign bus_data = bus_data_q;
    assign bus_vld  = bus_vld_q;

endmodule

// File: tb/tb_dut_bus_arb.sv
// Table-driven bench for dut_bus_arb: per-cycle control vectors plus a scoreboard
// of acked beats that must appear on the bus one cycle later.
module tb_dut_bus_arb;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [1:0] len;
        logic [3:0] lock;
        logic [3:0] gnt;
        logic [3:0] ack;
        logic       busy;
        logic       vld;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [7:0]  req_len;
    logic [15:0] req_cmd;
    logic [15:0] req_adr;
    logic [15:0] req_data;
`ifdef DUT_ARB_LOCK_EN
    logic [3:0]  req_lock;
`endif
    logic [3:0]  gnt;
    logic [3:0]  beat_ack;
    logic [3:0]  bus_cmd;
    logic [3:0]  bus_adr;
    logic [3:0]  bus_data;
    logic        bus_vld;
    logic        busy;

    int          n_vec;
    int          n_bad;
    vec_t        tbl[$];
    logic [11:0] sb_q[$];

    dut_bus_arb #(.NUM_REQ(4), .W(4), .LEN_W(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_len  (req_len),
        .req_cmd  (req_cmd),
        .req_adr  (req_adr),
        .req_data (req_data),
`ifdef DUT_ARB_LOCK_EN
        .req_lock (req_lock),
`endif
        .gnt      (gnt),
        .beat_ack (beat_ack),
        .bus_cmd  (bus_cmd),
        .bus_adr  (bus_adr),
        .bus_data (bus_data),
        .bus_vld  (bus_vld),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (vector %0d)", name, act, exp, n_vec);
        end
    endtask

    function automatic void add(input logic r, input logic [3:0] rq, input logic [1:0] ln,
                                input logic [3:0] lk, input logic [3:0] g, input logic [3:0] a,
                                input logic b, input logic v);
        vec_t e;
        e.rst = r; e.req = rq; e.len = ln; e.lock = lk;
        e.gnt = g; e.ack = a; e.busy = b; e.vld = v;
        tbl.push_back(e);
    endfunction

    // Drive one cycle at the falling edge, check, then record any beat expected to be consumed.
    task automatic apply(input vec_t v);
        logic [11:0] e;
        @(negedge clk);
        rst      = v.rst;
        req      = v.req;
        req_len  = {4{v.len}};
`ifdef DUT_ARB_LOCK_EN
        req_lock = v.lock;
`endif
        req_cmd  = 16'($urandom);
        req_adr  = 16'($urandom);
        req_data = 16'($urandom);
        #1;
        n_vec++;
        chk("gnt", 16'(gnt), 16'(v.gnt));
        chk("beat_ack", 16'(beat_ack), 16'(v.ack));
        chk("busy", 16'(busy), 16'(v.busy));
        chk("bus_vld", 16'(bus_vld), 16'(v.vld));
        if (v.vld) begin
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_empty: got bus beat %0h, expected none queued (vector %0d)",
                         {bus_cmd, bus_adr, bus_data}, n_vec);
            end else begin
                e = sb_q.pop_front();
                chk("bus_beat", 16'({bus_cmd, bus_adr, bus_data}), 16'(e));
            end
        end else begin
            chk("bus_nop", 16'({bus_cmd, bus_adr, bus_data}), 16'h0000);
        end
        for (int i = 0; i < 4; i++) begin
            if (v.ack[i]) begin
                sb_q.push_back({req_cmd[i*4 +: 4], req_adr[i*4 +: 4], req_data[i*4 +: 4]});
            end
        end
    endtask

    initial begin
        int  acks;
        int  vlds;
        bit  found;
        n_vec    = 0;
        n_bad    = 0;
        rst      = 1'b1;
        req      = 4'h0;
        req_len  = 8'h00;
        req_cmd  = 16'h0000;
        req_adr  = 16'h0000;
        req_data = 16'h0000;
`ifdef DUT_ARB_LOCK_EN
        req_lock = 4'h0;
`endif
        repeat (2) @(posedge clk);

        //  rst  req    len   lock   gnt    ack   busy  vld
        add(1'b1, 4'h0, 2'd0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        // single requester, 3-beat burst
        add(1'b0, 4'h1, 2'd2, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        add(1'b0, 4'h1, 2'd2, 4'h0, 4'h1, 4'h1, 1'b1, 1'b0);
        add(1'b0, 4'h1, 2'd2, 4'h0, 4'h1, 4'h1, 1'b1, 1'b1);
        add(1'b0, 4'h0, 2'd2, 4'h0, 4'h1, 4'h1, 1'b1, 1'b1);
        add(1'b0, 4'h0, 2'd2, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        add(1'b0, 4'h0, 2'd2, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        // all requesters, single beats: 0,1,2,3,0 with an idle cycle between
        add(1'b1, 4'h0, 2'd0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        add(1'b0, 4'hF, 2'd0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        add(1'b0, 4'hF, 2'd0, 4'h0, 4'h1, 4'h1, 1'b1, 1'b0);
        add(1'b0, 4'hF, 2'd0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        add(1'b0, 4'hF, 2'd0, 4'h0, 4'h2, 4'h2, 1'b1, 1'b0);
        add(1'b0, 4'hF, 2'd0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        add(1'b0, 4'hF, 2'd0, 4'h0, 4'h4, 4'h4, 1'b1, 1'b0);
        add(1'b0, 4'hF, 2'd0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        add(1'b0, 4'hF, 2'd0, 4'h0, 4'h8, 4'h8, 1'b1, 1'b0);
        add(1'b0, 4'hF, 2'd0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        add(1'b0, 4'h0, 2'd0, 4'h0, 4'h1, 4'h1, 1'b1, 1'b0);
        add(1'b0, 4'h0, 2'd0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        add(1'b0, 4'h0, 2'd0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        // requesters 1 and 3 after reset: 1, 3, 1
        add(1'b1, 4'h0, 2'd0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        add(1'b0, 4'hA, 2'd0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        add(1'b0, 4'hA, 2'd0, 4'h0, 4'h2, 4'h2, 1'b1, 1'b0);
        add(1'b0, 4'hA, 2'd0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        add(1'b0, 4'hA, 2'd0, 4'h0, 4'h8, 4'h8, 1'b1, 1'b0);
        add(1'b0, 4'hA, 2'd0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        add(1'b0, 4'h0, 2'd0, 4'h0, 4'h2, 4'h2, 1'b1, 1'b0);
        add(1'b0, 4'h0, 2'd0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        add(1'b0, 4'h0, 2'd0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        // requester 2, 4 beats; req and req_len change mid-burst
        add(1'b0, 4'h4, 2'd3, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        add(1'b0, 4'h4, 2'd3, 4'h0, 4'h4, 4'h4, 1'b1, 1'b0);
        add(1'b0, 4'h0, 2'd0, 4'h0, 4'h4, 4'h4, 1'b1, 1'b1);
        add(1'b0, 4'h0, 2'd0, 4'h0, 4'h4, 4'h4, 1'b1, 1'b1);
        add(1'b0, 4'h0, 2'd0, 4'h0, 4'h4, 4'h4, 1'b1, 1'b1);
        add(1'b0, 4'h0, 2'd0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        add(1'b0, 4'h0, 2'd0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        // reset on the 2nd beat of a 4-beat burst to requester 1; pointer restarts at 0
        add(1'b0, 4'h2, 2'd3, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        add(1'b0, 4'h2, 2'd3, 4'h0, 4'h2, 4'h2, 1'b1, 1'b0);
        add(1'b1, 4'h2, 2'd3, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
        add(1'b0, 4'h5, 2'd0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        add(1'b0, 4'h0, 2'd0, 4'h0, 4'h1, 4'h1, 1'b1, 1'b0);
        add(1'b0, 4'h0, 2'd0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        add(1'b0, 4'h0, 2'd0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
`ifdef DUT_ARB_LOCK_EN
        // requester 0 locked: four gapless beats, one IDLE, then requester 1
        add(1'b1, 4'h0, 2'd0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        add(1'b0, 4'h3, 2'd0, 4'h1, 4'h0, 4'h0, 1'b0, 1'b0);
        add(1'b0, 4'h3, 2'd0, 4'h1, 4'h1, 4'h1, 1'b1, 1'b0);
        add(1'b0, 4'h3, 2'd0, 4'h1, 4'h1, 4'h1, 1'b1, 1'b1);
        add(1'b0, 4'h3, 2'd0, 4'h1, 4'h1, 4'h1, 1'b1, 1'b1);
        add(1'b0, 4'h3, 2'd0, 4'h1, 4'h1, 4'h1, 1'b1, 1'b1);
        add(1'b0, 4'h3, 2'd0, 4'h1, 4'h0, 4'h0, 1'b0, 1'b1);
        add(1'b0, 4'h0, 2'd0, 4'h0, 4'h2, 4'h2, 1'b1, 1'b0);
        add(1'b0, 4'h0, 2'd0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        add(1'b0, 4'h0, 2'd0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
`endif

        for (int n = 0; n < tbl.size(); n++) begin
            apply(tbl[n]);
        end

        // Hand sequence: requester 3, 2-beat burst, grant awaited within a cycle budget.
        @(negedge clk);
        rst     = 1'b0;
        req     = 4'h8;
        req_len = {4{2'd1}};
        found   = 1'b0;
        for (int c = 0; c < 6 && !found; c++) begin
            @(negedge clk);
            #1;
            found = (gnt == 4'h8);
        end
        n_vec++;
        chk("hand_gnt_wait", 16'(found), 16'h0001);
        acks = int'(beat_ack[3]);
        vlds = int'(bus_vld);
        req  = 4'h0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            acks += int'(beat_ack[3]);
            vlds += int'(bus_vld);
        end
        n_vec++;
        chk("hand_ack_count", 16'(acks), 16'd2);
        chk("hand_vld_count", 16'(vlds), 16'd2);
        chk("scoreboard_drained", 16'(sb_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dut_bus_arb.md
# dut_bus_arb

Round-robin arbiter and burst sequencer that shares the single cmd/adr/data bus of the DUT interface between `NUM_REQ` requesters. Each requester posts a burst of 1 to 2^`LEN_W` beats. The arbiter grants one requester at a time and drives that requester's beats onto the registered bus outputs, which feed the interface's `master` modport. Grant and bus activity are visible to the interface's per-clock sampling and coverage.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `W`, default 4: width of each of cmd, adr and data.
- `LEN_W`, default 2: burst-length field width; the field holds beats minus 1.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `req`, in, `NUM_REQ`: request per requester.
- `req_len`, in, `NUM_REQ*LEN_W`: beats minus 1, packed; requester i occupies slice i.
- `req_cmd`, in, `NUM_REQ*W`: per-requester command, packed.
- `req_adr`, in, `NUM_REQ*W`: per-requester address, packed.
- `req_data`, in, `NUM_REQ*W`: per-requester data, packed.
- `gnt`, out, `NUM_REQ`: one-hot grant, registered.
- `beat_ack`, out, `NUM_REQ`: the current beat of the granted requester is consumed at this edge.
- `bus_cmd`, out, `W`: bus command, registered.
- `bus_adr`, out, `W`: bus address, registered.
- `bus_data`, out, `W`: bus data, registered.
- `bus_vld`, out, 1: bus holds a valid beat.
- `busy`, out, 1: high in XFER.
- `req_lock`, in, `NUM_REQ`: present only with `DUT_ARB_LOCK_EN`.

## Operation
- State machine with two states, IDLE and XFER.
  - IDLE: if `req` is non-zero, select a winner, load `gnt` one-hot, load `beat_cnt` from the winner's `req_len`, and go to XFER. Otherwise stay in IDLE with `gnt` = 0.
  - XFER: every cycle `beat_ack[w]` = 1 for the winner w. At the edge, the bus registers load w's cmd, adr and data, `bus_vld` is set to 1, and `beat_cnt` decrements.
  - When `beat_cnt` = 0 at the edge, the burst ends: `gnt` is cleared and the state returns to IDLE.
- Round-robin selection:
  - Pointer `last` holds the index of the previous winner.
  - The search starts at `last`+1 and wraps modulo `NUM_REQ`; the first set `req` bit wins.
  - `last` updates when the grant is issued.
- `req` is sampled only in IDLE. Deasserting `req` or changing `req_len` during XFER does not shorten the burst. The requester holds each beat's fields stable until it sees `beat_ack`.
- `beat_cnt` is `LEN_W` bits wide; its decrement never wraps because the exit condition is checked first.
- While `bus_vld` = 0, `bus_cmd`, `bus_adr` and `bus_data` are 0 (NOP).
- `beat_ack` is combinational and equals `gnt` gated by state XFER and by `!rst`.
- Reset values: `gnt`=0, `bus_*`=0, `bus_vld`=0, `busy`=0, `beat_ack`=0, state=IDLE, `last`=`NUM_REQ`-1, so requester 0 is favoured first.
- Reset during XFER aborts the burst at that edge. No further `beat_ack` is issued, and `bus_vld` is 0 on the next cycle.

## Timing
- Cycle 0: `req` is high in IDLE.
- Cycle 1: `gnt` and `beat_ack` are high.
- Cycle 2: the first beat is on the bus with `bus_vld`=1.
- A burst of L+1 beats holds `beat_ack` for cycles 1..1+L and `bus_vld` for cycles 2..2+L.
- Back-to-back bursts without lock have exactly one IDLE cycle between the last `beat_ack` of one burst and the next `gnt`. The bus sees one `bus_vld`=0 gap cycle.
- Bus data latency from `beat_ack` to the bus is exactly 1 cycle.

## Configuration
- `DUT_ARB_LOCK_EN` defined:
  - The `req_lock` port exists.
  - At burst end, if `req_lock[w]` and `req[w]` are both high, the arbiter stays in XFER with `gnt` unchanged and reloads `beat_cnt` from `req_len[w]`. There is no gap cycle, and `last` is not updated.
  - A lock is honoured for at most 4 consecutive bursts. After that the arbiter returns to IDLE for one cycle.
- `DUT_ARB_LOCK_EN` undefined: the port is absent and every burst end returns to IDLE.

## Test plan
- Single requester: `req`=4'b0001, `req_len[0]`=2, cmd/adr/data incrementing per ack. Expect:
  - `gnt`=0001 on cycle 1.
  - `beat_ack[0]` on cycles 1-3.
  - `bus_vld` on cycles 2-4 carrying the three acked beats.
  - `gnt`=0 on cycle 4.
- All requesters request continuously, each with `req_len`=0. Expect grants in the order 0,1,2,3,0, with one idle cycle between each.
- Requesters 1 and 3 only, after reset: 1 is granted first, then 3, then 1.
- `req` for requester 2 drops mid-burst with `req_len`=3: all 4 beats are still acked and driven, and `busy` stays high for 4 cycles.
- `rst` is asserted on the 2nd beat of a 4-beat burst. Expect:
  - `gnt`=0 and `beat_ack`=0 from the `rst` cycle.
  - `bus_vld`=0 from the next cycle.
  - The next grant goes to requester 0 if it is requesting.
- With `DUT_ARB_LOCK_EN`: requester 0 holds `req_lock` with `req_len`=0 while requester 1 also requests. Expect 4 consecutive beats to requester 0 with no gap, then IDLE, then a grant to requester 1.
